// File: rtl/sequence_generator.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sequence_generator
//
// Serial pattern transmitter. A WIDTH-bit word is accepted over a valid/ready
// handshake and shifted out MSB-first on `seq`, one bit per clock. A fixed
// idle gap of GAP_CYCLES zero cycles follows each frame, and completed frames
// are counted in a wrapping counter.
//
// Optional feature (compile-time macro SEQ_GEN_PARITY_EN):
//   When defined, an even-parity bit (XOR of the word) is appended after the
//   last data bit and carries seq_last. When undefined, no parity logic exists.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   pat_data   in   [WIDTH-1:0] pattern word, sampled on handshake
//   pat_valid  in   pat_data is valid
//   pat_ready  out  block accepts a word this cycle
//   seq        out  serial bit stream (0 whenever seq_valid=0)
//   seq_valid  out  seq carries a frame bit this cycle
//   seq_last   out  high with the final bit of a frame
//   busy       out  frame or gap in progress
//   frame_cnt  out  [CNT_W-1:0] completed frames, wraps silently
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sequence_generator #(
  parameter int WIDTH      = 4,  // 2..16
  parameter int GAP_CYCLES = 1,  // 0..15
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_data,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             seq_last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

`ifdef SEQ_GEN_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int               BIT_W    = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  // The gap counter counts down to zero, so it is loaded with one less than
  // the number of gap cycles.
  localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_e;

  state_e           state_q,     state_d;
  logic [WIDTH-1:0] shift_q,     shift_d;
  logic [BIT_W-1:0] bit_q,       bit_d;
  logic [3:0]       gap_q,       gap_d;
  logic             pat_ready_q, pat_ready_d;
  logic             busy_q,      busy_d;
  logic             seq_q,       seq_d;
  logic             seq_valid_q, seq_valid_d;
  logic             seq_last_q,  seq_last_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [BIT_W-1:0] bit_inc;
`ifdef SEQ_GEN_PARITY_EN
  logic             parity_q,    parity_d;
`endif

  assign bit_inc = bit_q + 1'b1;

  // Next-state and next-output logic.
  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    pat_ready_d = pat_ready_q;
    busy_d      = busy_q;
    seq_d       = seq_q;
    seq_valid_d = seq_valid_q;
    seq_last_d  = seq_last_q;
    frame_cnt_d = frame_cnt_q;
`ifdef SEQ_GEN_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // pat_ready rises on the first edge after reset, so the handshake is
        // qualified with the registered ready, never with pat_valid alone.
        pat_ready_d = 1'b1;
        busy_d      = 1'b0;
        seq_d       = 1'b0;
        seq_valid_d = 1'b0;
        seq_last_d  = 1'b0;
        if (pat_valid && pat_ready_q) begin
          shift_d     = pat_data;
          bit_d       = '0;
          pat_ready_d = 1'b0;
          busy_d      = 1'b1;
          seq_d       = pat_data[WIDTH-1];
          seq_valid_d = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
          parity_d    = ^pat_data;
`endif
          state_d     = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (bit_q == LAST_BIT) begin
          seq_d       = 1'b0;
          seq_valid_d = 1'b0;
          seq_last_d  = 1'b0;
          frame_cnt_d = frame_cnt_q + 1'b1;
          if (GAP_CYCLES > 0) begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end else begin
            pat_ready_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
          end
        end else begin
          // shift_q[WIDTH-1] is the bit on the line now, so the next one is
          // always at WIDTH-2 before the register moves up.
          shift_d    = {shift_q[WIDTH-2:0], 1'b0};
          seq_d      = shift_q[WIDTH-2];
          bit_d      = bit_inc;
          seq_last_d = (bit_inc == LAST_BIT);
`ifdef SEQ_GEN_PARITY_EN
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            seq_d = parity_q;
          end
`endif
        end
      end

      ST_GAP: begin
        if (gap_q == 4'd0) begin
          pat_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the values from before the edge, independent of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      pat_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      seq_q       <= 1'b0;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
      frame_cnt_q <= '0;
`ifdef SEQ_GEN_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      pat_ready_q <= pat_ready_d;
      busy_q      <= busy_d;
      seq_q       <= seq_d;
      seq_valid_q <= seq_valid_d;
      seq_last_q  <= seq_last_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef SEQ_GEN_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign pat_ready = pat_ready_q;
  assign seq       = seq_q;
  assign seq_valid = seq_valid_q;
  assign seq_last  = seq_last_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule
